// File: rtl/ex_branch_pkg.sv
// Shared definitions for the EX-stage branch target block: widths and skid-stage state encoding.
package ex_branch_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int TAKEN_W    = 1;
  localparam int MISALIGN_W = 1;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/bt_entry_reg.sv
// One buffered branch entry (target, taken, pc_plus4, optional misalign) with load enable.
// The misalign field exists only when BRANCH_MISALIGN_CHK_EN is defined.
module bt_entry_reg
  import ex_branch_pkg::*;
#(
  parameter int                 DATA_W   = DATA_W_DEF,
  parameter logic [DATA_W-1:0]  PC_RESET = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_W-1:0]     target_d,
  input  logic [TAKEN_W-1:0]    taken_d,
  input  logic [DATA_W-1:0]     pc_plus4_d,
`ifdef BRANCH_MISALIGN_CHK_EN
  input  logic [MISALIGN_W-1:0] misalign_d,
  output logic [MISALIGN_W-1:0] misalign_q,
`endif
  output logic [DATA_W-1:0]     target_q,
  output logic [TAKEN_W-1:0]    taken_q,
  output logic [DATA_W-1:0]     pc_plus4_q
);

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      target_q   <= PC_RESET;
      taken_q    <= '0;
      pc_plus4_q <= PC_RESET;
    end else if (load) begin
      target_q   <= target_d;
      taken_q    <= taken_d;
      pc_plus4_q <= pc_plus4_d;
    end
  end

`ifdef BRANCH_MISALIGN_CHK_EN
  always_ff @(posedge clk) begin
    if (reset)     misalign_q <= '0;
    else if (load) misalign_q <= misalign_d;
  end
`endif

endmodule

// File: rtl/ex_branch_target.sv
// EX-stage branch target adder and beq/bne resolution behind a 2-entry skid buffer.
// Optional PC+4 misalignment flag enabled by defining BRANCH_MISALIGN_CHK_EN.
module ex_branch_target
  import ex_branch_pkg::*;
#(
  parameter int                DATA_W   = DATA_W_DEF,
  parameter logic [DATA_W-1:0] PC_RESET = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pc_plus4,
  input  logic [DATA_W-1:0] in_offset_sl2,
  input  logic              in_zero,
  input  logic              in_branch_eq,
  input  logic              in_branch_ne,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_target,
  output logic              out_taken,
  output logic [DATA_W-1:0] out_pc_plus4,
  output logic              out_misalign
);

  state_e            state_q, state_d;
  logic              accept, out_xfer, main_load, skid_load, from_skid;
  logic [DATA_W-1:0] new_target;
  logic              new_taken;
  logic [DATA_W-1:0] skid_target_q, skid_pc_plus4_q;
  logic              skid_taken_q;
  logic [DATA_W-1:0] main_target_d, main_pc_plus4_d;
  logic              main_taken_d;

  // Carry out of the adder is dropped: targets wrap modulo 2^DATA_W.
  assign new_target = in_pc_plus4 + in_offset_sl2;
  assign new_taken  = (in_branch_eq & in_zero) | (in_branch_ne & ~in_zero);

  assign in_ready  = (state_q != ST_FULL) && !reset;
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_EMPTY;
    else       state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    main_load = 1'b0;
    skid_load = 1'b0;
    case (state_q)
      ST_EMPTY: if (accept) begin
        state_d   = ST_ONE;
        main_load = 1'b1;
      end
      ST_ONE: begin
        if (accept && out_xfer) begin
          main_load = 1'b1;
        end else if (accept) begin
          state_d   = ST_FULL;
          skid_load = 1'b1;
        end else if (out_xfer) begin
          state_d   = ST_EMPTY;
        end
      end
      ST_FULL: if (out_xfer) begin
        state_d   = ST_ONE;
        main_load = 1'b1;
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush wins over any accept; the incoming entry is simply never stored.
    if (flush) begin
      state_d   = ST_EMPTY;
      main_load = 1'b0;
      skid_load = 1'b0;
    end
  end

  assign from_skid       = (state_q == ST_FULL);
  assign main_target_d   = from_skid ? skid_target_q   : new_target;
  assign main_taken_d    = from_skid ? skid_taken_q    : new_taken;
  assign main_pc_plus4_d = from_skid ? skid_pc_plus4_q : in_pc_plus4;

`ifdef BRANCH_MISALIGN_CHK_EN
  logic new_misalign, skid_misalign_q, main_misalign_d, main_misalign_q;
  assign new_misalign    = |in_pc_plus4[1:0];
  assign main_misalign_d = from_skid ? skid_misalign_q : new_misalign;
  assign out_misalign    = main_misalign_q;
`else
  assign out_misalign    = 1'b0;
`endif

  bt_entry_reg #(.DATA_W(DATA_W), .PC_RESET(PC_RESET)) u_main (
    .clk        (clk),
    .reset      (reset),
    .load       (main_load),
    .target_d   (main_target_d),
    .taken_d    (main_taken_d),
    .pc_plus4_d (main_pc_plus4_d),
`ifdef BRANCH_MISALIGN_CHK_EN
    .misalign_d (main_misalign_d),
    .misalign_q (main_misalign_q),
`endif
    .target_q   (out_target),
    .taken_q    (out_taken),
    .pc_plus4_q (out_pc_plus4)
  );

  bt_entry_reg #(.DATA_W(DATA_W), .PC_RESET(PC_RESET)) u_skid (
    .clk        (clk),
    .reset      (reset),
    .load       (skid_load),
    .target_d   (new_target),
    .taken_d    (new_taken),
    .pc_plus4_d (in_pc_plus4),
`ifdef BRANCH_MISALIGN_CHK_EN
    .misalign_d (new_misalign),
    .misalign_q (skid_misalign_q),
`endif
    .target_q   (skid_target_q),
    .taken_q    (skid_taken_q),
    .pc_plus4_q (skid_pc_plus4_q)
  );

endmodule

// File: tb/tb_ex_branch_target.sv
// Randomized and directed bench for ex_branch_target against a queue-based reference model.
// Misalign expectations follow BRANCH_MISALIGN_CHK_EN when it is defined for the build.
module tb_ex_branch_target;

  localparam logic [31:0] PC_RST = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_zero, in_branch_eq, in_branch_ne, out_ready;
  logic [31:0] in_pc_plus4, in_offset_sl2;
  logic        in_ready, out_valid, out_taken, out_misalign;
  logic [31:0] out_target, out_pc_plus4;

  always #5 clk = ~clk;

  ex_branch_target #(.DATA_W(32), .PC_RESET(PC_RST)) dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_pc_plus4   (in_pc_plus4),
    .in_offset_sl2 (in_offset_sl2),
    .in_zero       (in_zero),
    .in_branch_eq  (in_branch_eq),
    .in_branch_ne  (in_branch_ne),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_target    (out_target),
    .out_taken     (out_taken),
    .out_pc_plus4  (out_pc_plus4),
    .out_misalign  (out_misalign)
  );

  typedef struct {
    logic [31:0] target;
    logic        taken;
    logic [31:0] pc;
    logic        mis;
  } exp_t;

  exp_t q[$];          // entries held by the block, oldest first
  bit   fresh;         // no entry stored since reset: fields must show reset values
  int   vectors     = 0;
  int   miscompares = 0;

  function automatic exp_t model_entry(input logic [31:0] pc, off, input logic z, eq, ne);
    exp_t e;
    e.target = pc + off;
    case ({eq, ne})
      2'b10:   e.taken = z;
      2'b01:   e.taken = !z;
      2'b11:   e.taken = 1'b1;
      default: e.taken = 1'b0;
    endcase
    e.pc = pc;
`ifdef BRANCH_MISALIGN_CHK_EN
    e.mis = (pc % 4) != 0;
`else
    e.mis = 1'b0;
`endif
    return e;
  endfunction

  // One clock: drive inputs after negedge, compare against the model, advance the model at posedge.
  task automatic apply(input logic rst, fl, iv, input logic [31:0] pc, off,
                       input logic z, eq, ne, ordy, output bit acc);
    bit   exp_rdy, exp_vld, xfer;
    exp_t h;
    @(negedge clk);
    reset = rst; flush = fl; in_valid = iv; in_pc_plus4 = pc; in_offset_sl2 = off;
    in_zero = z; in_branch_eq = eq; in_branch_ne = ne; out_ready = ordy;
    #1;
    exp_rdy = !rst && (q.size() < 2);
    exp_vld = (q.size() > 0);
    vectors++;
    if (in_ready !== exp_rdy) begin
      miscompares++;
      $display("FAIL in_ready @%0t: got %b want %b", $time, in_ready, exp_rdy);
    end
    vectors++;
    if (out_valid !== exp_vld) begin
      miscompares++;
      $display("FAIL out_valid @%0t: got %b want %b", $time, out_valid, exp_vld);
    end
    if (exp_vld || fresh) begin
      if (exp_vld) h = q[0];
      else begin h.target = PC_RST; h.taken = 1'b0; h.pc = PC_RST; h.mis = 1'b0; end
      vectors++;
      if (out_target !== h.target || out_taken !== h.taken ||
          out_pc_plus4 !== h.pc || out_misalign !== h.mis) begin
        miscompares++;
        $display("FAIL out_fields @%0t: got tgt=%h tk=%b pc=%h mis=%b want tgt=%h tk=%b pc=%h mis=%b",
                 $time, out_target, out_taken, out_pc_plus4, out_misalign,
                 h.target, h.taken, h.pc, h.mis);
      end
    end
    acc  = iv && exp_rdy;
    xfer = exp_vld && ordy;
    @(posedge clk);
    if (rst) begin
      q.delete();
      fresh = 1'b1;
    end else if (fl) begin
      q.delete();
      fresh = 1'b0;
    end else begin
      if (xfer) void'(q.pop_front());
      if (acc) begin
        q.push_back(model_entry(pc, off, z, eq, ne));
        fresh = 1'b0;
      end
    end
  endtask

  task automatic idle(input logic ordy);
    bit a;
    apply(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, ordy, a);
  endtask

  task automatic test_reset();
    bit a;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc_plus4 = '0; in_offset_sl2 = '0; in_zero = 1'b0; in_branch_eq = 1'b0; in_branch_ne = 1'b0;
    repeat (2) @(posedge clk);
    q.delete();
    fresh = 1'b1;
    apply(1'b1, 1'b0, 1'b1, 32'h4, 32'h4, 1'b1, 1'b1, 1'b0, 1'b1, a);  // in_ready low in reset
    idle(1'b1);
  endtask

  task automatic test_basic();
    bit a;
    apply(1'b0, 1'b0, 1'b1, 32'h0000_0104, 32'h0000_0010, 1'b1, 1'b1, 1'b0, 1'b1, a);
    #1;
    vectors++;
    if (out_valid !== 1'b1 || out_target !== 32'h0000_0114 || out_taken !== 1'b1) begin
      miscompares++;
      $display("FAIL beq_basic: got v=%b tgt=%h tk=%b want v=1 tgt=00000114 tk=1",
               out_valid, out_target, out_taken);
    end
    apply(1'b0, 1'b0, 1'b1, 32'h0000_0200, 32'hFFFF_FFF0, 1'b1, 1'b0, 1'b1, 1'b1, a);
    #1;
    vectors++;
    if (out_target !== 32'h0000_01F0 || out_taken !== 1'b0) begin
      miscompares++;
      $display("FAIL bne_backward: got tgt=%h tk=%b want tgt=000001f0 tk=0", out_target, out_taken);
    end
    apply(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0000_0008, 1'b0, 1'b1, 1'b1, 1'b1, a);
    #1;
    vectors++;
    if (out_target !== 32'h0000_0004 || out_taken !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap_both_set: got tgt=%h tk=%b want tgt=00000004 tk=1", out_target, out_taken);
    end
    idle(1'b1);
  endtask

  task automatic test_backpressure();
    bit a;
    int waited;
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b0, 1'b1, 32'h0000_3000 + 32'(i * 16), 32'h40, 1'b1, 1'b1, 1'b0, 1'b0, a);
      if (i == 1) begin
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL bp_full_ready: got %b want 0", in_ready);
        end
      end
    end
    // Keep offering entry 3 with out_ready high until taken; model checks order and uniqueness.
    waited = 0;
    a = 1'b0;
    while (!a && waited < 8) begin
      apply(1'b0, 1'b0, 1'b1, 32'h0000_3020, 32'h40, 1'b1, 1'b1, 1'b0, 1'b1, a);
      waited++;
    end
    vectors++;
    if (!a) begin
      miscompares++;
      $display("FAIL bp_third_accept: got none within %0d cycles want accept", waited);
    end
    repeat (3) idle(1'b1);
  endtask

  task automatic test_flush();
    bit a;
    apply(1'b0, 1'b0, 1'b1, 32'h0000_5000, 32'h8, 1'b1, 1'b1, 1'b0, 1'b0, a);
    apply(1'b0, 1'b0, 1'b1, 32'h0000_5004, 32'h8, 1'b0, 1'b0, 1'b1, 1'b0, a);
    apply(1'b0, 1'b1, 1'b1, 32'h0000_5008, 32'h8, 1'b0, 1'b0, 1'b1, 1'b0, a);
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_full: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
    end
    // Flush while EMPTY with an offered entry: that entry must also vanish.
    apply(1'b0, 1'b1, 1'b1, 32'h0000_500C, 32'h8, 1'b1, 1'b1, 1'b0, 1'b1, a);
    repeat (2) idle(1'b1);
  endtask

  task automatic test_reset_mid();
    bit a;
    apply(1'b0, 1'b0, 1'b1, 32'h0000_0102, 32'h20, 1'b1, 1'b1, 1'b0, 1'b0, a);
`ifdef BRANCH_MISALIGN_CHK_EN
    #1;
    vectors++;
    if (out_misalign !== 1'b1) begin
      miscompares++;
      $display("FAIL misalign: got %b want 1", out_misalign);
    end
`endif
    apply(1'b1, 1'b0, 1'b1, 32'h0000_0200, 32'h20, 1'b1, 1'b1, 1'b0, 1'b0, a);
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_target !== PC_RST || out_taken !== 1'b0 || out_misalign !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: got v=%b tgt=%h tk=%b mis=%b want v=0 tgt=%h tk=0 mis=0",
               out_valid, out_target, out_taken, out_misalign, PC_RST);
    end
    idle(1'b1);
  endtask

  task automatic test_random();
    bit a;
    for (int i = 0; i < 600; i++) begin
      apply(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 5),
            ($urandom_range(0, 99) < 70), $urandom, $urandom,
            1'($urandom), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 99) < 60), a);
    end
  endtask

  task automatic test_back_to_back();
    bit a;
    for (int i = 0; i < 20; i++)
      apply(1'b0, 1'b0, 1'b1, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom), 1'b1, a);
    repeat (2) idle(1'b1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ex_branch_target.md
Name: ex_branch_target

Overview:
- EX-stage block directly downstream of the immediate left-shift-by-2 unit.
- Adds the word-aligned branch offset to PC+4 and resolves beq/bne taken from the ALU zero flag.
- Presents target/taken to the MEM/PC-select logic through a 2-entry skid-buffered valid/ready stage, with flush support.

Parameters:
DATA_W, 32, width of PC, offset and target
PC_RESET, 32'h0000_0000, reset value of out_target and out_pc_plus4

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
flush  in  1  discard all buffered entries (branch mispredict / exception)
in_valid  in  1  upstream entry valid
in_ready  out  1  block can accept an entry this cycle
in_pc_plus4  in  DATA_W  PC+4 of the branch instruction
in_offset_sl2  in  DATA_W  sign-extended immediate already shifted left by 2
in_zero  in  1  ALU zero flag (rs == rt)
in_branch_eq  in  1  instruction is beq
in_branch_ne  in  1  instruction is bne
out_valid  out  1  output entry valid
out_ready  in  1  downstream accepts the entry this cycle
out_target  out  DATA_W  in_pc_plus4 + in_offset_sl2
out_taken  out  1  branch taken
out_pc_plus4  out  DATA_W  forwarded PC+4 (fall-through address)
out_misalign  out  1  PC+4 misaligned flag (see Optional Feature)

Behaviour:
- Transfers: input on in_valid && in_ready; output on out_valid && out_ready.
- Arithmetic: target = in_pc_plus4 + in_offset_sl2, modulo 2^DATA_W. Wrap-around is silent; the carry is dropped.
- taken = (in_branch_eq & in_zero) | (in_branch_ne & ~in_zero). If both eq and ne are set, taken = 1.
- State machine, outputs always driven from the main register:
  - EMPTY: no entries.
  - ONE: main register valid.
  - FULL: main and skid registers valid.
- Transitions:
  - EMPTY -> ONE on accept.
  - ONE -> EMPTY on output transfer without accept.
  - ONE stays ONE on accept together with output transfer; the new entry goes into main.
  - ONE -> FULL on accept without output transfer; the new entry goes into skid.
  - FULL -> ONE on output transfer; skid moves to main.
- in_ready = (state != FULL) && !reset. Decoded combinationally from the state register only; it never depends on out_ready.
- Latency: an accepted entry appears on the outputs in the next cycle when the block was EMPTY, or when it was ONE with an output transfer that cycle.
- Throughput: 1 entry/cycle while out_ready is held high.
- out_valid = (state != EMPTY).
- Output fields hold stable while out_valid && !out_ready.
- Flush: next state is EMPTY and out_valid = 0 in the following cycle. Flush has priority over a simultaneous accept; the accepted entry is dropped. A simultaneous output transfer is still counted as completed.
- Reset, synchronous and valid mid-operation:
  - state EMPTY; out_valid 0; out_taken 0; out_misalign 0.
  - out_target and out_pc_plus4 = PC_RESET.
  - Buffered entries are discarded.
- Data registers need not be cleared on flush; only the valid state is.

Optional Feature:
- Macro BRANCH_MISALIGN_CHK_EN.
- Defined: out_misalign = |in_pc_plus4[1:0], captured with the entry and travelling with it through the skid path.
- Undefined: out_misalign is tied to 0 and no extra flops are built. The port exists in both builds.

Decomposition:
- Package ex_branch_pkg: DATA_W default; state encodings ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2; entry field widths.
- One natural sub-module: bt_entry_reg, a clocked entry register (target, taken, pc_plus4, misalign) with load enable. Instantiated twice, as main and skid.
- Adder and taken logic stay in the top module.

Test Plan:
- Basic beq: pc_plus4=0x0000_0104, offset=0x0000_0010, zero=1, eq=1, out_ready=1. Expect next cycle out_valid=1, target=0x0000_0114, taken=1.
- bne backward: pc_plus4=0x0000_0200, offset=0xFFFF_FFF0, zero=1, ne=1. Expect target=0x0000_01F0, taken=0.
- Wrap: pc_plus4=0xFFFF_FFFC, offset=0x0000_0008. Expect target=0x0000_0004, no error.
- Backpressure: stream 3 entries with out_ready=0.
  - in_ready drops after the 2nd accept; state FULL; 3rd entry not accepted.
  - Raise out_ready: entries emerge in order 1, 2, then 3 once accepted; no loss or duplication.
- Flush in FULL with in_valid=1 the same cycle. Expect out_valid=0 next cycle, in_ready=1, the flushed-cycle input not emitted.
- Reset mid-stream in state ONE. Expect next cycle out_valid=0, out_target=PC_RESET, out_taken=0.
  - With BRANCH_MISALIGN_CHK_EN: pc_plus4=0x0000_0102 gives out_misalign=1.
